pe_accumulator: RTL and testbench
=================================

Name: pe_accumulator

Overview:
- Output-side accumulation stage that sits directly downstream of the PE adder tree.
- Registers each 20-bit PE sum and feeds it back as previous_sum, so a dot product spanning num_steps input beats is built up over successive cycles.
- After the last beat, presents the final result on a valid/ready output port and holds it until the consumer accepts it.

Parameters:
- ACC_W, 20, accumulator / PE sum width (two's complement).
- LEN_W, 8, width of the step counter and num_steps.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request to begin a new accumulation; sampled only in IDLE.
- num_steps  input  LEN_W  number of PE sums to accumulate; sampled with start.
- busy  output  1  high in ACC or DONE.
- in_valid  input  1  pe_sum carries a valid beat.
- in_ready  output  1  block accepts a beat this cycle.
- pe_sum  input  ACC_W  sum from the adder tree, which already includes previous_sum.
- previous_sum  output  ACC_W  running accumulator fed back to the adder tree.
- out_valid  output  1  out_data holds a final result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  ACC_W  final accumulated result.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - acc=0, cnt=0, out_data=0.
  - busy=0, in_ready=0, out_valid=0, previous_sum=0.
  - Reset mid-ACC or mid-DONE discards the partial or pending result; no output beat is produced.
- State IDLE:
  - in_ready=0, out_valid=0, previous_sum=0.
  - start=1 with num_steps>0: next state ACC, acc<=0, cnt<=num_steps.
  - start=1 with num_steps=0: next state DONE, out_data<=0 (an empty dot product yields zero).
- State ACC:
  - in_ready=1.
  - previous_sum=acc, combinationally from the register (no extra latency), so the adder output in the same cycle equals acc plus the products.
  - A beat is accepted when in_valid & in_ready.
  - On an accepted beat with cnt>1: acc<=pe_sum, cnt<=cnt-1.
  - On an accepted beat with cnt==1: out_data<=pe_sum, acc<=0, next state DONE.
  - in_valid=0: acc and cnt hold. Bubbles are allowed and add no cycles beyond the stall.
- State DONE:
  - out_valid=1, in_ready=0; out_data stable.
  - previous_sum=0, so no stale feedback reaches the adder tree.
  - out_valid & out_ready: next state IDLE, out_valid drops the following cycle.
  - out_ready low: hold indefinitely with out_data unchanged.
- start outside IDLE is ignored: no queuing, no effect on cnt, acc or out_data.
- start in the same cycle as the DONE handshake is also ignored; a new start is accepted no earlier than the first IDLE cycle.
- Arithmetic:
  - pe_sum is registered as-is.
  - Overflow wraps modulo 2^ACC_W, matching the adder tree; no saturation and no flag.
- Throughput and latency:
  - Back-to-back beats are accepted every cycle in ACC.
  - out_valid rises 1 cycle after the last accepted beat.
  - Minimum job = 1 (start) + N (beats) + 1 (output) cycles.
- No combinational path from out_ready to in_ready, and none from in_valid to any output other than through registers; previous_sum depends only on state and acc.

Test Plan:
- Reset then start with num_steps=3; model the adder as pe_sum=previous_sum+X with X=5, -2, 10 on consecutive cycles.
  - Required: previous_sum sequence 0, 5, 3.
  - Required: out_valid one cycle after the 3rd beat, out_data=13 (0x0000D).
- num_steps=4 with in_valid toggling 1,0,1,0,1,1 and X=1 per beat.
  - Required: exactly 4 beats accepted, acc holds during bubbles, out_data=4.
- Result held with out_ready=0 for 5 cycles, start pulsed meanwhile.
  - Required: out_valid stays 1, out_data unchanged, start ignored.
  - Required: after out_ready=1, IDLE the next cycle, busy=0.
- num_steps=0 start.
  - Required: next cycle DONE with out_data=0, in_ready never asserted.
- Wrap-around: num_steps=2, X=0x7FFFF then X=1.
  - Required: out_data=0x80000 (wrapped), no error.
- Assert rst mid-ACC after 2 of 5 beats.
  - Required: outputs zero immediately (async), no out_valid.
  - Required: a following job with num_steps=1, X=7 yields out_data=7 (no residue from the aborted job).

Source files
------------

// File: rtl/pe_accumulator.sv
// Output-side accumulator for the PE adder tree: feeds the running sum back as
// previous_sum, counts num_steps beats, then holds the result on a valid/ready port.
module pe_accumulator #(
  parameter int ACC_W = 20,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] num_steps,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] pe_sum,
  output logic [ACC_W-1:0] previous_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

  // Handshakes: a beat moves when in_valid & in_ready; the result moves when
  // out_valid & out_ready. All outputs derive from registered state only.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_steps != '0) begin
            state_d = S_ACC;
            acc_d   = '0;
            cnt_d   = num_steps;
          end else begin
            state_d    = S_DONE;
            out_data_d = '0;
          end
        end
      end
      S_ACC: begin
        if (in_valid) begin
          if (cnt_q > LEN_W'(1)) begin
            acc_d = pe_sum;
            cnt_d = cnt_q - LEN_W'(1);
          end else begin
            out_data_d = pe_sum;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Feedback is zero outside ACC so no stale sum reaches the adder tree.
  assign busy         = (state_q != S_IDLE);
  assign in_ready     = (state_q == S_ACC);
  assign out_valid    = (state_q == S_DONE);
  assign previous_sum = (state_q == S_ACC) ? acc_q : '0;
  assign out_data     = out_data_q;

endmodule

// File: tb/tb_pe_accumulator.sv
// Bench for pe_accumulator: table vectors, hand-written corner sequences and
// randomized jobs checked against a running-sum model of the dot product.
module tb_pe_accumulator;

  localparam int ACC_W = 20;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] num_steps = '0;
  logic             busy;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ACC_W-1:0] pe_sum = '0;
  logic [ACC_W-1:0] previous_sum;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [ACC_W-1:0] xs [0:15];

  typedef struct {
    int               n;
    logic [ACC_W-1:0] x [4];
    logic [ACC_W-1:0] exp_res;
  } vec_t;
  vec_t tbl [6];

  pe_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_steps(num_steps), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .pe_sum(pe_sum),
    .previous_sum(previous_sum), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job with beats xs[0..n-1]; the adder tree is modelled as
  // pe_sum = previous_sum + x. The model tracks the running dot product.
  task automatic do_job(input int n, input int bubble_pct, input int hold,
                        input logic [ACC_W-1:0] exp_res);
    logic [ACC_W-1:0] run;
    int acc_cnt;
    int guard;
    start = 1'b1;
    num_steps = LEN_W'(n);
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("in_ready_after_start", in_ready, (n > 0) ? 1 : 0);
    run = '0;
    acc_cnt = 0;
    guard = 0;
    while (acc_cnt < n && guard < 2000) begin
      check("prev_sum", previous_sum, run);
      check("in_ready_acc", in_ready, 1);
      check("out_valid_acc", out_valid, 0);
      in_valid = ($urandom_range(99) >= bubble_pct);
      pe_sum = previous_sum + xs[acc_cnt];
      tick();
      if (in_valid) begin
        run = run + xs[acc_cnt];
        acc_cnt++;
      end
      guard++;
    end
    in_valid = 1'b0;
    if (acc_cnt < n) check("beat_timeout", acc_cnt, n);
    check("out_valid_done", out_valid, 1);
    check("out_data_done", out_data, exp_res);
    check("in_ready_done", in_ready, 0);
    check("prev_sum_done", previous_sum, 0);
    check("busy_done", busy, 1);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      start = (i == hold / 2);
      num_steps = 8'd3;
      tick();
      check("hold_out_valid", out_valid, 1);
      check("hold_out_data", out_data, exp_res);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    check("idle_out_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 0);
    check("idle_prev_sum", previous_sum, 0);
    tick();
    check("idle_stays", busy, 0);
  endtask

  initial begin
    logic [ACC_W-1:0] model_sum;
    int n;
    int pattern [6];

    tbl[0].n = 3; tbl[0].x[0] = 20'd5;      tbl[0].x[1] = 20'hFFFFE; tbl[0].x[2] = 20'd10;     tbl[0].x[3] = 20'd0;      tbl[0].exp_res = 20'h0000D;
    tbl[1].n = 2; tbl[1].x[0] = 20'h7FFFF;  tbl[1].x[1] = 20'd1;     tbl[1].x[2] = 20'd0;      tbl[1].x[3] = 20'd0;      tbl[1].exp_res = 20'h80000;
    tbl[2].n = 1; tbl[2].x[0] = 20'd7;      tbl[2].x[1] = 20'd0;     tbl[2].x[2] = 20'd0;      tbl[2].x[3] = 20'd0;      tbl[2].exp_res = 20'd7;
    tbl[3].n = 0; tbl[3].x[0] = 20'd9;      tbl[3].x[1] = 20'd0;     tbl[3].x[2] = 20'd0;      tbl[3].x[3] = 20'd0;      tbl[3].exp_res = 20'd0;
    tbl[4].n = 4; tbl[4].x[0] = 20'd1;      tbl[4].x[1] = 20'd1;     tbl[4].x[2] = 20'd1;      tbl[4].x[3] = 20'd1;      tbl[4].exp_res = 20'd4;
    tbl[5].n = 4; tbl[5].x[0] = 20'hFFFFF;  tbl[5].x[1] = 20'hFFFFF; tbl[5].x[2] = 20'hFFFFF;  tbl[5].x[3] = 20'hFFFFF;  tbl[5].exp_res = 20'hFFFFC;

    // Clock/reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_prev_sum", previous_sum, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    tick();

    // Table vectors; the first uses a 5-cycle hold with start pulsed meanwhile.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 4; k++) xs[k] = tbl[t].x[k];
      do_job(tbl[t].n, 0, (t == 0) ? 5 : 1, tbl[t].exp_res);
    end

    // Bubble pattern 1,0,1,0,1,1 with X=1: acc holds through bubbles.
    pattern = '{1, 0, 1, 0, 1, 1};
    start = 1'b1;
    num_steps = 8'd4;
    tick();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      check("bub_prev_sum", previous_sum, n);
      check("bub_out_valid", out_valid, 0);
      in_valid = pattern[i][0];
      pe_sum = previous_sum + 20'd1;
      tick();
      if (pattern[i] != 0) n++;
    end
    in_valid = 1'b0;
    check("bub_out_valid_end", out_valid, 1);
    check("bub_out_data", out_data, 4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bub_idle", busy, 0);

    // Async reset after 2 of 5 beats.
    start = 1'b1;
    num_steps = 8'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      pe_sum = previous_sum + 20'd3;
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_prev_sum", previous_sum, 6);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_prev_sum", previous_sum, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_out_valid", out_valid, 0);
    xs[0] = 20'd7;
    do_job(1, 0, 0, 20'd7);

    // Randomized jobs against the running-sum model.
    for (int j = 0; j < 25; j++) begin
      n = $urandom_range(12);
      model_sum = '0;
      for (int k = 0; k < n; k++) begin
        xs[k] = ACC_W'($urandom);
        model_sum = model_sum + xs[k];
      end
      do_job(n, 30, $urandom_range(3), model_sum);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
